// File: rtl/route_collector_pkg.sv
// -----------------------------------------------------------------------------
// route_collector_pkg
// Shared definitions for the route collector and its helpers.
//   - Default sizes: CHANNEL_NUM / CAPACITOR_NUM, overridable with the
//     `CHANNEL_NUM and `CAPACITOR_NUM macros, plus derived index widths.
//   - FSM state encoding (IDLE/SCAN/EMIT/DONE).
//   - Polarity constants: an occupied capacitor and a requested channel are
//     both marked by a 0 bit (the distributor fills unused slots with 1).
// Optional feature macro used by the top: ROUTE_COLLECTOR_ERR_EN.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef CHANNEL_NUM
  `define CHANNEL_NUM 8
`endif
`ifndef CAPACITOR_NUM
  `define CAPACITOR_NUM 16
`endif

package route_collector_pkg;

  localparam int DEF_CHANNEL_NUM   = `CHANNEL_NUM;
  localparam int DEF_CAPACITOR_NUM = `CAPACITOR_NUM;
  localparam int DEF_CH_W          = $clog2(DEF_CHANNEL_NUM);
  localparam int DEF_CAP_W         = $clog2(DEF_CAPACITOR_NUM);

  // Bit value meaning "occupied" in the capacitor map and "requested" in
  // the channel mask.
  localparam logic OCC = 1'b0;
  localparam logic REQ = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/route_lsb_finder.sv
// -----------------------------------------------------------------------------
// route_lsb_finder
// Combinational lowest-matching-bit finder. Returns the index of the lowest
// bit of vec equal to MATCH (0 by default) and a found flag. Shared with the
// distributor side of the capacitor chain.
// Ports:
//   vec    in   W    vector to search
//   idx    out  IW   index of the lowest matching bit (0 when none)
//   found  out  1    at least one bit matches
// -----------------------------------------------------------------------------
module route_lsb_finder #(
  parameter int   W     = 8,
  parameter int   IW    = (W > 1) ? $clog2(W) : 1,
  parameter logic MATCH = 1'b0
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan upward; the first hit freezes the result so the lowest index wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!found && (vec[i] == MATCH)) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_collector.sv
// -----------------------------------------------------------------------------
// route_collector
// Reads back a capacitor occupancy map and pairs the k-th occupied capacitor
// with the k-th requested channel (lowest index first), walking capacitors
// from index 0 upward at one per clock. Each pair is offered on a
// valid/ready handshake and accumulated into a channel grant map.
// Optional feature: define ROUTE_COLLECTOR_ERR_EN to add the err output,
// flagging scans that end with unpaired capacitors or ungranted channels.
// Ports:
//   clk         in   1              rising-edge clock
//   rst         in   1              synchronous active-high reset
//   start       in   1              pulse; latches maps and starts a scan (IDLE only)
//   cap_map     in   CAPACITOR_NUM  occupancy, 0 = occupied
//   chan_req    in   CHANNEL_NUM    request mask, 0 = requested
//   pair_valid  out  1              pair available
//   pair_ready  in   1              consumer accepts the pair
//   pair_chan   out  CH_W           channel index of the pair
//   pair_cap    out  CAP_W          capacitor index of the pair
//   grant_map   out  CHANNEL_NUM    1 = channel paired in this scan
//   pair_cnt    out  CAP_W+1        pairs emitted in this scan
//   busy        out  1              high outside IDLE
//   done        out  1              one-cycle pulse at end of scan
//   err         out  1              (ROUTE_COLLECTOR_ERR_EN) sticky mismatch flag
// -----------------------------------------------------------------------------
module route_collector
  import route_collector_pkg::*;
#(
  parameter int CHANNEL_NUM   = DEF_CHANNEL_NUM,
  parameter int CAPACITOR_NUM = DEF_CAPACITOR_NUM,
  parameter int CH_W          = $clog2(CHANNEL_NUM),
  parameter int CAP_W         = $clog2(CAPACITOR_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CAPACITOR_NUM-1:0] cap_map,
  input  logic [CHANNEL_NUM-1:0]   chan_req,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  output logic [CH_W-1:0]          pair_chan,
  output logic [CAP_W-1:0]         pair_cap,
  output logic [CHANNEL_NUM-1:0]   grant_map,
  output logic [CAP_W:0]           pair_cnt,
  output logic                     busy,
  output logic                     done
`ifdef ROUTE_COLLECTOR_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPACITOR_NUM - 1);

  state_t                   state_reg;
  logic [CAPACITOR_NUM-1:0] cap_lat_reg;   // remaining occupancy (paired caps set to 1)
  logic [CHANNEL_NUM-1:0]   req_rem_reg;   // remaining requests (granted chans set to 1)
  logic [CAP_W-1:0]         cap_ptr_reg;
  logic                     pair_valid_reg;
  logic [CH_W-1:0]          pair_chan_reg;
  logic [CAP_W-1:0]         pair_cap_reg;
  logic [CHANNEL_NUM-1:0]   grant_reg;
  logic [CAP_W:0]           cnt_reg;
  logic                     busy_reg;
  logic                     done_reg;
`ifdef ROUTE_COLLECTOR_ERR_EN
  logic                     err_reg;
`endif

  logic [CH_W-1:0]          free_chan;
  logic                     chan_found;
  logic                     cap_occ;
  logic                     at_last;
  logic                     xfer;
  logic [CHANNEL_NUM-1:0]   req_after;
  logic [CAPACITOR_NUM-1:0] cap_after;

  route_lsb_finder #(
    .W     (CHANNEL_NUM),
    .IW    (CH_W),
    .MATCH (REQ)
  ) u_chan_finder (
    .vec   (req_rem_reg),
    .idx   (free_chan),
    .found (chan_found)
  );

  assign cap_occ   = (cap_lat_reg[cap_ptr_reg] == OCC);
  assign at_last   = (cap_ptr_reg == CAP_LAST);
  assign xfer      = pair_valid_reg & pair_ready;
  // Maps as they will look once the pair currently offered is accepted.
  assign req_after = req_rem_reg | (CHANNEL_NUM'(1) << pair_chan_reg);
  assign cap_after = cap_lat_reg | (CAPACITOR_NUM'(1) << pair_cap_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cap_lat_reg    <= '1;
      req_rem_reg    <= '1;
      cap_ptr_reg    <= '0;
      pair_valid_reg <= 1'b0;
      pair_chan_reg  <= '0;
      pair_cap_reg   <= '0;
      grant_reg      <= '0;
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef ROUTE_COLLECTOR_ERR_EN
      err_reg        <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cap_lat_reg <= cap_map;
            req_rem_reg <= chan_req;
            grant_reg   <= '0;
            cnt_reg     <= '0;
            cap_ptr_reg <= '0;
            busy_reg    <= 1'b1;
`ifdef ROUTE_COLLECTOR_ERR_EN
            err_reg     <= 1'b0;
`endif
            state_reg   <= SCAN;
          end
        end

        SCAN: begin
          if (!chan_found) begin
            // Every requested channel already granted: nothing left to pair.
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else if (cap_occ) begin
            pair_chan_reg  <= free_chan;
            pair_cap_reg   <= cap_ptr_reg;
            pair_valid_reg <= 1'b1;
            state_reg      <= EMIT;
          end else if (at_last) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            cap_ptr_reg <= cap_ptr_reg + CAP_W'(1);
          end
        end

        EMIT: begin
          if (xfer) begin
            pair_valid_reg <= 1'b0;
            grant_reg      <= grant_reg | (CHANNEL_NUM'(1) << pair_chan_reg);
            req_rem_reg    <= req_after;
            cap_lat_reg    <= cap_after;
            cnt_reg        <= cnt_reg + (CAP_W + 1)'(1);
            // The pointer saturates: after the last capacitor the scan ends
            // rather than wrapping to index 0.
            if ((&req_after) || at_last) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              cap_ptr_reg <= cap_ptr_reg + CAP_W'(1);
              state_reg   <= SCAN;
            end
          end
        end

        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef ROUTE_COLLECTOR_ERR_EN
          // Any 0 left in either remaining map is an unpaired capacitor
          // (overflow) or an ungranted channel (underflow).
          err_reg   <= (~&cap_lat_reg) | (~&req_rem_reg);
`endif
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pair_valid = pair_valid_reg;
  assign pair_chan  = pair_chan_reg;
  assign pair_cap   = pair_cap_reg;
  assign grant_map  = grant_reg;
  assign pair_cnt   = cnt_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
`ifdef ROUTE_COLLECTOR_ERR_EN
  assign err        = err_reg;
`endif

endmodule

// File: tb/tb_route_collector.sv
// -----------------------------------------------------------------------------
// tb_route_collector
// Directed self-checking bench for route_collector (CHANNEL_NUM=8,
// CAPACITOR_NUM=16). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, so each check sees the state left
// by the preceding edge. Optional err checks follow ROUTE_COLLECTOR_ERR_EN.
// -----------------------------------------------------------------------------
module tb_route_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cap_map;
  logic [7:0]  chan_req;
  logic        pair_valid;
  logic        pair_ready;
  logic [2:0]  pair_chan;
  logic [3:0]  pair_cap;
  logic [7:0]  grant_map;
  logic [4:0]  pair_cnt;
  logic        busy;
  logic        done;
`ifdef ROUTE_COLLECTOR_ERR_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  route_collector #(
    .CHANNEL_NUM   (8),
    .CAPACITOR_NUM (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cap_map    (cap_map),
    .chan_req   (chan_req),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_chan  (pair_chan),
    .pair_cap   (pair_cap),
    .grant_map  (grant_map),
    .pair_cnt   (pair_cnt),
    .busy       (busy),
    .done       (done)
`ifdef ROUTE_COLLECTOR_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pair_valid"}, 32'(pair_valid), 32'h0);
    check({tag, ".pair_chan"},  32'(pair_chan),  32'h0);
    check({tag, ".pair_cap"},   32'(pair_cap),   32'h0);
    check({tag, ".grant_map"},  32'(grant_map),  32'h0);
    check({tag, ".pair_cnt"},   32'(pair_cnt),   32'h0);
    check({tag, ".busy"},       32'(busy),       32'h0);
    check({tag, ".done"},       32'(done),       32'h0);
`ifdef ROUTE_COLLECTOR_ERR_EN
    check({tag, ".err"},        32'(err),        32'h0);
`endif
  endtask

  // Pulse start for one edge, then scramble the inputs so any use of the
  // live inputs instead of the latched copies shows up.
  task automatic do_start(input logic [15:0] c, input logic [7:0] r);
    cap_map  = c;
    chan_req = r;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cap_map  = 16'h0000;
    chan_req = 8'h00;
  endtask

  // chan_req=FA (chans 0,2), cap_map=FFF9 (caps 1,2): pairs (0,1) at cycle 3,
  // (2,2) at cycle 5, done at cycle 6, idle at cycle 7.
  task automatic run_basic(input string tag, input bit busy_start);
    pair_ready = 1'b1;
    do_start(16'hFFF9, 8'hFA);
    check({tag, ".c1.busy"},  32'(busy),       32'h1);
    check({tag, ".c1.valid"}, 32'(pair_valid), 32'h0);
    tick();
    check({tag, ".c2.valid"}, 32'(pair_valid), 32'h0);
    if (busy_start) begin
      cap_map  = 16'h0000;
      chan_req = 8'h00;
      start    = 1'b1;
    end
    tick();
    start = 1'b0;
    check({tag, ".c3.valid"}, 32'(pair_valid), 32'h1);
    check({tag, ".c3.chan"},  32'(pair_chan),  32'h0);
    check({tag, ".c3.cap"},   32'(pair_cap),   32'h1);
    tick();
    check({tag, ".c4.valid"}, 32'(pair_valid), 32'h0);
    check({tag, ".c4.cnt"},   32'(pair_cnt),   32'h1);
    check({tag, ".c4.grant"}, 32'(grant_map),  32'h01);
    tick();
    check({tag, ".c5.valid"}, 32'(pair_valid), 32'h1);
    check({tag, ".c5.chan"},  32'(pair_chan),  32'h2);
    check({tag, ".c5.cap"},   32'(pair_cap),   32'h2);
    tick();
    check({tag, ".c6.done"},  32'(done),       32'h1);
    check({tag, ".c6.busy"},  32'(busy),       32'h1);
    check({tag, ".c6.valid"}, 32'(pair_valid), 32'h0);
    check({tag, ".c6.cnt"},   32'(pair_cnt),   32'h2);
    check({tag, ".c6.grant"}, 32'(grant_map),  32'h05);
    tick();
    check({tag, ".c7.done"},  32'(done),       32'h0);
    check({tag, ".c7.busy"},  32'(busy),       32'h0);
    check({tag, ".c7.cnt"},   32'(pair_cnt),   32'h2);
    check({tag, ".c7.grant"}, 32'(grant_map),  32'h05);
`ifdef ROUTE_COLLECTOR_ERR_EN
    check({tag, ".c7.err"},   32'(err),        32'h0);
`endif
    $display("txn %s: pairs (0,1),(2,2) cnt=%0d grant=%02h", tag, pair_cnt, grant_map);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cap_map    = 16'hFFFF;
    chan_req   = 8'hFF;
    pair_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");
    $display("txn reset: outputs cleared");

    // Basic pairing.
    run_basic("basic", 1'b0);

    // Backpressure: hold pair_ready low for the first 5 cycles of the pair.
    pair_ready = 1'b0;
    do_start(16'hFFF9, 8'hFA);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.hold.valid", 32'(pair_valid), 32'h1);
      check("bp.hold.chan",  32'(pair_chan),  32'h0);
      check("bp.hold.cap",   32'(pair_cap),   32'h1);
      check("bp.hold.cnt",   32'(pair_cnt),   32'h0);
      tick();
    end
    pair_ready = 1'b1;
    check("bp.rel.valid", 32'(pair_valid), 32'h1);
    tick();
    check("bp.after.valid", 32'(pair_valid), 32'h0);
    check("bp.after.cnt",   32'(pair_cnt),   32'h1);
    tick();
    check("bp.p2.valid", 32'(pair_valid), 32'h1);
    check("bp.p2.chan",  32'(pair_chan),  32'h2);
    check("bp.p2.cap",   32'(pair_cap),   32'h2);
    tick();
    check("bp.done",  32'(done),      32'h1);
    check("bp.cnt",   32'(pair_cnt),  32'h2);
    check("bp.grant", 32'(grant_map), 32'h05);
    tick();
    check("bp.idle", 32'(busy), 32'h0);
    $display("txn backpressure: held 5 cycles, cnt=%0d grant=%02h", pair_cnt, grant_map);

    // Empty scan: no occupied capacitor, every channel requesting.
    do_start(16'hFFFF, 8'h00);
    for (int i = 1; i < 17; i++) begin
      check("empty.nodone",  32'(done),       32'h0);
      check("empty.novalid", 32'(pair_valid), 32'h0);
      tick();
    end
    check("empty.done",  32'(done),      32'h1);
    check("empty.cnt",   32'(pair_cnt),  32'h0);
    check("empty.grant", 32'(grant_map), 32'h00);
    tick();
    check("empty.idle", 32'(busy), 32'h0);
`ifdef ROUTE_COLLECTOR_ERR_EN
    check("empty.err", 32'(err), 32'h1);
`endif
    $display("txn empty: done at cycle 17, cnt=%0d", pair_cnt);

    // Overflow: caps 0-3 occupied, only channel 0 requesting.
    do_start(16'hFFF0, 8'hFE);
    tick();
    check("ovf.valid", 32'(pair_valid), 32'h1);
    check("ovf.chan",  32'(pair_chan),  32'h0);
    check("ovf.cap",   32'(pair_cap),   32'h0);
    tick();
    check("ovf.done",  32'(done),      32'h1);
    check("ovf.grant", 32'(grant_map), 32'h01);
    check("ovf.cnt",   32'(pair_cnt),  32'h1);
    tick();
    check("ovf.idle", 32'(busy), 32'h0);
`ifdef ROUTE_COLLECTOR_ERR_EN
    check("ovf.err", 32'(err), 32'h1);
`endif
    $display("txn overflow: single pair (0,0), grant=%02h", grant_map);

    // Reset while a pair is being offered.
    pair_ready = 1'b0;
    do_start(16'hFFF9, 8'hFA);
`ifdef ROUTE_COLLECTOR_ERR_EN
    check("rstemit.err_cleared", 32'(err), 32'h0);
`endif
    tick();
    tick();
    check("rstemit.valid", 32'(pair_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rstemit");
    tick();
    check("rstemit.stay_idle", 32'(busy), 32'h0);
    $display("txn reset mid-EMIT: outputs cleared");
    run_basic("post_rst", 1'b0);

    // Start pulse during SCAN must be ignored.
    run_basic("busy_start", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
